uart_param_bank: RTL and testbench

- Parametrised, register-addressed successor to the single-word UART pulse-parameter loader.
- Receives framed commands as bytes from an external uart byte interface and writes or reads back any of NUM_REGS parameter registers. Frame: PAYLOAD_BYTES data bytes, little-endian, then one control byte.
- Drives a flat parameter bus consumed by the pulse generator. Adds read-back, address checking, an inter-byte timeout and per-write update strobes.

---
 rtl/param_bank_pkg.sv | 30 +++
 rtl/param_frame_rx.sv | 78 +++++++
 rtl/uart_param_bank.sv | 210 +++++++++++++++++++++
 tb/tb_uart_param_bank.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/param_bank_pkg.sv
// Shared types and constants for the UART parameter bank.
package param_bank_pkg;

  // Command sequencer states
  typedef enum logic [1:0] {
    ST_RECV      = 2'd0,
    ST_EXEC      = 2'd1,
    ST_SEND      = 2'd2,
    ST_SEND_WAIT = 2'd3
  } state_t;

  // Control byte layout: {read, addr[6:0]}
  localparam int unsigned CTRL_READ_BIT = 7;
  localparam int unsigned CTRL_ADDR_MSB = 6;
  localparam int unsigned UPD_ADDR_W    = 7;

  // upd_addr value reported when the whole bank is committed at once
  localparam logic [UPD_ADDR_W-1:0] ADDR_ALL = 7'h7F;

  // Register indices inherited from the single-word pulse-parameter loader
  localparam logic [UPD_ADDR_W-1:0] ADDR_DELAY    = 7'd0;
  localparam logic [UPD_ADDR_W-1:0] ADDR_PERIOD   = 7'd1;
  localparam logic [UPD_ADDR_W-1:0] ADDR_PULSE1   = 7'd2;
  localparam logic [UPD_ADDR_W-1:0] ADDR_PULSE2   = 7'd3;
  localparam logic [UPD_ADDR_W-1:0] ADDR_BLOCK    = 7'd4;
  localparam logic [UPD_ADDR_W-1:0] ADDR_CPMG     = 7'd5;
  localparam logic [UPD_ADDR_W-1:0] ADDR_ATT      = 7'd6;
  localparam logic [UPD_ADDR_W-1:0] ADDR_NUTATION = 7'd7;

endpackage

// File: rtl/param_frame_rx.sv
// Frame assembler: detects rx_valid rising edges, collects PAYLOAD_BYTES
// little-endian data bytes plus a control byte, and discards a partial
// frame after TIMEOUT_CYC idle cycles (0 disables the timeout).
module param_frame_rx
  import param_bank_pkg::*;
#(
  parameter int unsigned PAYLOAD_BYTES = 4,
  parameter int unsigned TIMEOUT_CYC   = 2_000_000
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         rx_valid,
  input  logic [7:0]                   rx_byte,
  input  logic                         enable,
  output logic                         frame_valid,
  output logic [8*PAYLOAD_BYTES-1:0]   payload,
  output logic [7:0]                   ctrl,
  output logic                         timeout
);

  localparam int unsigned CNT_W = $clog2(PAYLOAD_BYTES + 1);
  localparam int unsigned TO_W  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'((TIMEOUT_CYC == 0) ? 0 : TIMEOUT_CYC - 1);

  logic             rx_valid_q;
  logic [CNT_W-1:0] cnt;
  logic [TO_W-1:0]  to_cnt;
  logic             rx_edge_c;
  logic             to_fire_c;

  assign rx_edge_c = rx_valid & ~rx_valid_q;
  // Fires on the TIMEOUT_CYC-th idle cycle; takes priority over a coincident byte
  assign to_fire_c = (TIMEOUT_CYC != 0) && enable && (cnt != '0) && (to_cnt == TO_LAST);

  // Previous rx_valid for edge detection; tracked even while disabled so
  // edges during the response phase are consumed and dropped
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rx_valid_q <= 1'b0;
    else     rx_valid_q <= rx_valid;
  end

  // Byte assembly, frame completion and inter-byte timeout
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt         <= '0;
      to_cnt      <= '0;
      frame_valid <= 1'b0;
      timeout     <= 1'b0;
      payload     <= '0;
      ctrl        <= '0;
    end else begin
      frame_valid <= 1'b0;
      timeout     <= 1'b0;
      if (to_fire_c) begin
        cnt     <= '0;
        to_cnt  <= '0;
        timeout <= 1'b1;
      end else if (enable && rx_edge_c) begin
        to_cnt <= '0;
        if (cnt == CNT_W'(PAYLOAD_BYTES)) begin
          ctrl        <= rx_byte;
          cnt         <= '0;
          frame_valid <= 1'b1;
        end else begin
          for (int unsigned i = 0; i < PAYLOAD_BYTES; i++) begin
            if (cnt == CNT_W'(i)) payload[8*i +: 8] <= rx_byte;
          end
          cnt <= cnt + CNT_W'(1);
        end
      end else if (enable && (cnt != '0) && (TIMEOUT_CYC != 0)) begin
        to_cnt <= to_cnt + TO_W'(1);
      end else if (cnt == '0) begin
        to_cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/uart_param_bank.sv
// UART-addressed parameter register bank with read-back, address checking,
// inter-byte timeout and per-write update strobes.
// Optional feature macro: PARAM_BANK_SHADOW_COMMIT_EN (writes land in a shadow
// bank that is copied to regs_flat on the commit input).
module uart_param_bank
  import param_bank_pkg::*;
#(
  parameter int unsigned NUM_REGS      = 16,
  parameter int unsigned REG_W         = 32,
  parameter int unsigned PAYLOAD_BYTES = 4,
  parameter logic [NUM_REGS*REG_W-1:0] RESET_VALS = '0,
  parameter int unsigned TIMEOUT_CYC   = 2_000_000
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        rx_valid,
  input  logic [7:0]                  rx_byte,
  input  logic                        tx_busy,
`ifdef PARAM_BANK_SHADOW_COMMIT_EN
  input  logic                        commit,
`endif
  output logic                        tx_start,
  output logic [7:0]                  tx_byte,
  output logic [NUM_REGS*REG_W-1:0]   regs_flat,
  output logic                        upd_strobe,
  output logic [UPD_ADDR_W-1:0]       upd_addr,
  output logic                        rx_done,
  output logic                        frame_err
);

  localparam int unsigned PL_W   = 8 * PAYLOAD_BYTES;
  localparam int unsigned RESP_N = PAYLOAD_BYTES + 1;
  localparam int unsigned IDX_W  = $clog2(RESP_N + 1);

  logic                  frame_valid;
  logic                  to_pulse;
  logic [PL_W-1:0]       payload;
  logic [7:0]            ctrl;
  logic                  rx_en_c;

  state_t                state;
  logic [7:0]            resp [RESP_N];
  logic [IDX_W-1:0]      resp_len;
  logic [IDX_W-1:0]      resp_idx;
  logic [1:0]            guard;

  // Bank targeted by writes and read-back (the shadow bank when committing)
  logic [REG_W-1:0]      wr_bank [NUM_REGS];

  logic [UPD_ADDR_W-1:0] addr_c;
  logic                  is_read_c;
  logic                  addr_ok_c;
  logic                  exec_we_c;
  logic [7:0]            chk_c;
  logic [7:0]            rsum_c;
  logic [PL_W-1:0]       rdata_c;

  assign rx_en_c = (state == ST_RECV) && !frame_valid;

  param_frame_rx #(
    .PAYLOAD_BYTES (PAYLOAD_BYTES),
    .TIMEOUT_CYC   (TIMEOUT_CYC)
  ) u_frame_rx (
    .clk         (clk),
    .rst         (rst),
    .rx_valid    (rx_valid),
    .rx_byte     (rx_byte),
    .enable      (rx_en_c),
    .frame_valid (frame_valid),
    .payload     (payload),
    .ctrl        (ctrl),
    .timeout     (to_pulse)
  );

  assign addr_c    = ctrl[CTRL_ADDR_MSB:0];
  assign is_read_c = ctrl[CTRL_READ_BIT];
  assign addr_ok_c = 32'(addr_c) < NUM_REGS;
  assign exec_we_c = (state == ST_EXEC) && !is_read_c && addr_ok_c;

  // Payload checksum, read-back word and read-back checksum
  always_comb begin
    chk_c   = '0;
    rsum_c  = '0;
    rdata_c = '0;
    for (int unsigned i = 0; i < PAYLOAD_BYTES; i++) begin
      chk_c = chk_c + payload[8*i +: 8];
    end
    for (int unsigned r = 0; r < NUM_REGS; r++) begin
      if (addr_c == UPD_ADDR_W'(r)) rdata_c[REG_W-1:0] = wr_bank[r];
    end
    for (int unsigned i = 0; i < PAYLOAD_BYTES; i++) begin
      rsum_c = rsum_c + rdata_c[8*i +: 8];
    end
  end

  // Command sequencer: execute, then stream response bytes to the UART
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_RECV;
      resp_len  <= '0;
      resp_idx  <= '0;
      guard     <= '0;
      tx_start  <= 1'b0;
      tx_byte   <= '0;
      rx_done   <= 1'b0;
      frame_err <= 1'b0;
      for (int unsigned i = 0; i < RESP_N; i++) resp[i] <= '0;
    end else begin
      tx_start <= 1'b0;
      if (to_pulse) frame_err <= 1'b1;
      case (state)
        ST_RECV: begin
          if (frame_valid) state <= ST_EXEC;
        end
        ST_EXEC: begin
          resp_idx <= '0;
          rx_done  <= 1'b1;
          state    <= ST_SEND;
          if (!addr_ok_c) begin
            frame_err <= 1'b1;
            resp[0]   <= ~chk_c;
            resp_len  <= IDX_W'(1);
          end else if (is_read_c) begin
            for (int unsigned i = 0; i < PAYLOAD_BYTES; i++) resp[i] <= rdata_c[8*i +: 8];
            resp[PAYLOAD_BYTES] <= rsum_c;
            resp_len            <= IDX_W'(RESP_N);
          end else begin
            resp[0]  <= chk_c;
            resp_len <= IDX_W'(1);
          end
        end
        ST_SEND: begin
          if (!tx_busy) begin
            tx_start <= 1'b1;
            for (int unsigned i = 0; i < RESP_N; i++) begin
              if (resp_idx == IDX_W'(i)) tx_byte <= resp[i];
            end
            resp_idx <= resp_idx + IDX_W'(1);
            guard    <= '0;
            state    <= ST_SEND_WAIT;
          end
        end
        ST_SEND_WAIT: begin
          // tx_busy may lag tx_start, so it is not trusted for two cycles
          if (guard != 2'd2) begin
            guard <= guard + 2'd1;
          end else if (!tx_busy) begin
            if (resp_idx == resp_len) begin
              rx_done <= 1'b0;
              state   <= ST_RECV;
            end else begin
              state <= ST_SEND;
            end
          end
        end
        default: state <= ST_RECV;
      endcase
    end
  end

  // Register write from a valid write command
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned r = 0; r < NUM_REGS; r++) wr_bank[r] <= RESET_VALS[r*REG_W +: REG_W];
    end else if (exec_we_c) begin
      for (int unsigned r = 0; r < NUM_REGS; r++) begin
        if (addr_c == UPD_ADDR_W'(r)) wr_bank[r] <= payload[REG_W-1:0];
      end
    end
  end

`ifdef PARAM_BANK_SHADOW_COMMIT_EN
  logic [REG_W-1:0] act_bank [NUM_REGS];

  // Whole-bank copy from shadow to active on commit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      upd_strobe <= 1'b0;
      upd_addr   <= '0;
      for (int unsigned r = 0; r < NUM_REGS; r++) act_bank[r] <= RESET_VALS[r*REG_W +: REG_W];
    end else begin
      upd_strobe <= commit;
      if (commit) begin
        upd_addr <= ADDR_ALL;
        for (int unsigned r = 0; r < NUM_REGS; r++) act_bank[r] <= wr_bank[r];
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign regs_flat[g*REG_W +: REG_W] = act_bank[g];
  end
`else
  // Update strobe one cycle after each direct register write
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      upd_strobe <= 1'b0;
      upd_addr   <= '0;
    end else begin
      upd_strobe <= exec_we_c;
      if (exec_we_c) upd_addr <= addr_c;
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign regs_flat[g*REG_W +: REG_W] = wr_bank[g];
  end
`endif

endmodule

// File: tb/tb_uart_param_bank.sv
// Scoreboard bench for uart_param_bank: random frames checked against a
// byte-level model of the command protocol and a simple UART busy model.
module tb_uart_param_bank;

  localparam int unsigned NR = 16;
  localparam int unsigned RW = 32;
  localparam int unsigned PB = 4;
  localparam int unsigned TO = 100;

  function automatic logic [NR*RW-1:0] mk_img();
    logic [NR*RW-1:0] img;
    for (int unsigned i = 0; i < NR; i++) img[i*RW +: RW] = 32'hC0DE_0000 | 32'(i * 257);
    return img;
  endfunction

  localparam logic [NR*RW-1:0] RST_IMG = mk_img();

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             rx_valid = 1'b0;
  logic [7:0]       rx_byte = 8'h00;
  logic             tx_busy = 1'b0;
`ifdef PARAM_BANK_SHADOW_COMMIT_EN
  logic             commit = 1'b0;
`endif
  logic             tx_start;
  logic [7:0]       tx_byte;
  logic [NR*RW-1:0] regs_flat;
  logic             upd_strobe;
  logic [6:0]       upd_addr;
  logic             rx_done;
  logic             frame_err;

  always #5 clk = ~clk;

  uart_param_bank #(
    .NUM_REGS      (NR),
    .REG_W         (RW),
    .PAYLOAD_BYTES (PB),
    .RESET_VALS    (RST_IMG),
    .TIMEOUT_CYC   (TO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_valid   (rx_valid),
    .rx_byte    (rx_byte),
    .tx_busy    (tx_busy),
`ifdef PARAM_BANK_SHADOW_COMMIT_EN
    .commit     (commit),
`endif
    .tx_start   (tx_start),
    .tx_byte    (tx_byte),
    .regs_flat  (regs_flat),
    .upd_strobe (upd_strobe),
    .upd_addr   (upd_addr),
    .rx_done    (rx_done),
    .frame_err  (frame_err)
  );

  // Reference model state and scoreboard queues
  logic [RW-1:0] m_shadow [NR];
  logic [RW-1:0] m_active [NR];
  bit            m_err;
  logic [7:0]    exp_tx [$];
  logic [6:0]    exp_upd [$];
  int unsigned   n_checks = 0;
  int unsigned   n_pass = 0;
  int unsigned   busy_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic model_reset();
    for (int unsigned i = 0; i < NR; i++) begin
      m_shadow[i] = RST_IMG[i*RW +: RW];
      m_active[i] = RST_IMG[i*RW +: RW];
    end
    m_err = 1'b0;
    exp_tx.delete();
    exp_upd.delete();
  endtask

  // Expected response of one complete frame, from the protocol rules
  task automatic model_frame(input logic [8*PB-1:0] pl, input logic [7:0] c);
    int unsigned a;
    int unsigned s;
    int unsigned rs;
    logic [63:0] v;
    a = {25'd0, c[6:0]};
    s = 0;
    for (int unsigned i = 0; i < PB; i++) s += (64'(pl) >> (8 * i)) & 64'hFF;
    if (a >= NR) begin
      m_err = 1'b1;
      exp_tx.push_back(8'(255 - (s % 256)));
    end else if (c[7]) begin
      v  = 64'(m_shadow[a]);
      rs = 0;
      for (int unsigned i = 0; i < PB; i++) begin
        exp_tx.push_back(8'((v >> (8 * i)) & 64'hFF));
        rs += (v >> (8 * i)) & 64'hFF;
      end
      exp_tx.push_back(8'(rs % 256));
    end else begin
      m_shadow[a] = pl[RW-1:0];
`ifndef PARAM_BANK_SHADOW_COMMIT_EN
      m_active[a] = pl[RW-1:0];
      exp_upd.push_back(7'(a));
`endif
      exp_tx.push_back(8'(s % 256));
    end
  endtask

  task automatic check_regs(input string tag);
    for (int unsigned i = 0; i < NR; i++)
      check($sformatf("%s_reg%0d", tag, i), 64'(regs_flat[i*RW +: RW]), 64'(m_active[i]));
  endtask

  // One rx byte: rising edge on rx_valid for one cycle, then gap idle cycles
  task automatic send_byte(input logic [7:0] b, input int unsigned gap);
    @(posedge clk); #1;
    rx_byte  = b;
    rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    repeat (gap) @(posedge clk);
  endtask

  // Wait for the whole response phase; optionally poke a stray rx byte into it
  task automatic wait_resp(input bit inject);
    bit seen = 0;
    bit done = 0;
    bit injected = 0;
    for (int k = 0; k < 3000 && !done; k++) begin
      @(negedge clk);
      rx_valid = 1'b0;
      if (rx_done) begin
        seen = 1;
        if (inject && !injected) begin
          rx_byte  = 8'($urandom);
          rx_valid = 1'b1;
          injected = 1;
        end
      end else if (seen) begin
        done = 1;
      end
    end
    rx_valid = 1'b0;
    check("resp_complete", 64'(done), 64'd1);
  endtask

  task automatic send_frame(input logic [8*PB-1:0] pl, input logic [7:0] c,
                            input int unsigned gmin, input int unsigned gmax, input bit inject);
    for (int unsigned i = 0; i < PB; i++) send_byte(pl[8*i +: 8], $urandom_range(gmax, gmin));
    model_frame(pl, c);
    send_byte(c, 0);
    wait_resp(inject);
    check("tx_drained", 64'(exp_tx.size()), 64'd0);
    check("upd_drained", 64'(exp_upd.size()), 64'd0);
    check("frame_err", 64'(frame_err), 64'(m_err));
  endtask

  // Monitor: pops the scoreboard on tx_start / upd_strobe and models tx_busy
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (rst) begin
        tx_busy  = 1'b0;
        busy_cnt = 0;
      end else begin
        if (tx_start) begin
          check("tx_start_while_busy", 64'(tx_busy), 64'd0);
          check("rx_done_during_tx", 64'(rx_done), 64'd1);
          if (exp_tx.size() == 0) begin
            n_checks++;
            $display("FAIL tx_unexpected: got byte 0x%0h, expected no transmit", tx_byte);
          end else begin
            check("tx_byte", 64'(tx_byte), 64'(exp_tx.pop_front()));
          end
        end
        if (upd_strobe) begin
          if (exp_upd.size() == 0) begin
            n_checks++;
            $display("FAIL upd_unexpected: got upd_addr 0x%0h, expected no strobe", upd_addr);
          end else begin
            check("upd_addr", 64'(upd_addr), 64'(exp_upd.pop_front()));
          end
        end
        if (busy_cnt > 0) begin
          busy_cnt--;
          if (busy_cnt == 0) tx_busy = 1'b0;
        end
        if (tx_start) begin
          tx_busy  = 1'b1;
          busy_cnt = $urandom_range(10, 3);
        end
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : stim
    int          n_tx;
    bit          got;
    logic [7:0]  c;
    int unsigned kind;
    int unsigned k;

    model_reset();
    repeat (3) @(posedge clk);
    // Reset state
    check("rst_tx_start", 64'(tx_start), 64'd0);
    check("rst_upd_strobe", 64'(upd_strobe), 64'd0);
    check("rst_rx_done", 64'(rx_done), 64'd0);
    check("rst_frame_err", 64'(frame_err), 64'd0);
    check("rst_upd_addr", 64'(upd_addr), 64'd0);
    check("rst_tx_byte", 64'(tx_byte), 64'd0);
    check_regs("rst");
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);

    // Directed: write, read-back, bad address
    send_frame(32'h0000_2710, 8'h01, 0, 3, 0);
    check_regs("write1");
    send_frame(32'h0000_0000, 8'h81, 0, 3, 1);
    check_regs("read1");
    send_frame(32'h0403_0201, 8'h20, 0, 3, 0);
    check_regs("badaddr");

    // Reset during the response of a read
    for (int unsigned i = 0; i < PB; i++) send_byte(8'($urandom), 2);
    model_frame(32'h0, 8'h85);
    send_byte(8'h85, 0);
    got = 0;
    for (int i = 0; i < 500 && !got; i++) begin
      @(negedge clk);
      if (tx_start) got = 1;
    end
    check("saw_first_tx", 64'(got), 64'd1);
    rst = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    check_regs("rst_resp");
    check("rst_resp_frame_err", 64'(frame_err), 64'd0);
    rst = 1'b0;
    n_tx = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (tx_start) n_tx++;
    end
    check("no_tx_after_reset", 64'(n_tx), 64'd0);
    send_frame(32'hDEAD_BEEF, 8'h05, 0, 3, 0);
    check_regs("after_rst");

    // Reset mid-frame discards the partial frame
    send_byte(8'h11, 1);
    send_byte(8'h22, 1);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    send_frame(32'h1234_5678, 8'h06, 0, 3, 0);
    check_regs("after_midframe_rst");

    // Long but legal inter-byte gap, then a real timeout
    send_frame(32'hA5A5_5A5A, 8'h07, 95, 95, 0);
    check_regs("long_gap");
    send_byte(8'h99, 5);
    send_byte(8'h98, 120);
    m_err = 1'b1;
    check("timeout_err", 64'(frame_err), 64'd1);
    check("timeout_no_resp", 64'(rx_done), 64'd0);
    send_frame(32'h0BAD_F00D, 8'h03, 0, 5, 0);
    check_regs("after_timeout");

    // Randomized mix of commands, bad addresses and timeouts
    rst = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int n = 0; n < 40; n++) begin
      kind = $urandom_range(9, 0);
      if (kind == 0) begin
        c = 8'($urandom_range(127, NR)) | (8'($urandom_range(1, 0)) << 7);
        send_frame(32'($urandom), c, 0, 20, 1'($urandom_range(1, 0)));
      end else if (kind == 1) begin
        k = $urandom_range(PB, 1);
        for (int unsigned i = 0; i < k; i++) send_byte(8'($urandom), (i == k - 1) ? 120 : 3);
        m_err = 1'b1;
        check("rand_timeout_err", 64'(frame_err), 64'd1);
      end else begin
        c = 8'($urandom_range(NR - 1, 0)) | (8'($urandom_range(1, 0)) << 7);
        send_frame(32'($urandom), c, 0, 30, ($urandom_range(9, 0) < 3));
      end
      check_regs("rand");
    end

`ifdef PARAM_BANK_SHADOW_COMMIT_EN
    // Shadow write stays invisible until commit
    send_frame(32'h0000_0055, 8'h02, 0, 3, 0);
    check_regs("shadow_pre");
    @(posedge clk); #1;
    commit = 1'b1;
    for (int unsigned i = 0; i < NR; i++) m_active[i] = m_shadow[i];
    exp_upd.push_back(7'h7F);
    @(posedge clk); #1;
    commit = 1'b0;
    check_regs("shadow_post");
    repeat (2) @(posedge clk);
    check("commit_upd_drained", 64'(exp_upd.size()), 64'd0);
`endif

    repeat (10) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
